// File: rtl/wb_target_decode.sv
// Wishbone responder-side address decoder for the SPI bridge initiator.
// Routes one transaction at a time to RAM, REG, CRTC or KBD, with error and timeout.
module wb_target_decode #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int WB_ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_reset_i,

    input  logic [WB_ADDR_WIDTH-1:0]  wbi_addr_i,
    input  logic [DATA_WIDTH-1:0]     wbi_data_i,
    output logic [DATA_WIDTH-1:0]     wbi_data_o,
    input  logic                      wbi_we_i,
    input  logic                      wbi_cyc_i,
    input  logic                      wbi_stb_i,
    output logic                      wbi_stall_o,
    output logic                      wbi_ack_o,
    output logic                      wbi_err_o,

    output logic [WB_ADDR_WIDTH-1:0]  wbt_addr_o,
    output logic [DATA_WIDTH-1:0]     wbt_data_o,
    output logic                      wbt_we_o,
    output logic [3:0]                wbt_cyc_o,
    output logic [3:0]                wbt_stb_o,
    input  logic [3:0]                wbt_stall_i,
    input  logic [3:0]                wbt_ack_i,
    input  logic [4*DATA_WIDTH-1:0]   wbt_data_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]               state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     we_q,    we_d;
    logic [1:0]               sel_q,   sel_d;
    logic [15:0]              cnt_q,   cnt_d;
    logic                     ack_q,   ack_d;
    logic [3:0]               cyc_q,   cyc_d;
    logic [3:0]               stb_q,   stb_d;

    logic [3:0]               prefix;
    logic                     dec_hit;
    logic [1:0]               dec_sel;

    logic                     tgt_stall;
    logic                     tgt_ack;
    logic [DATA_WIDTH-1:0]    tgt_rdata;
    logic [15:0]              cnt_inc;
    logic                     timeout;
    logic                     take;

    // Target decode from the top address nibble; undecoded prefixes are unmapped.
    always_comb begin
        prefix  = wbi_addr_i[WB_ADDR_WIDTH-1 -: 4];
        dec_hit = 1'b1;
        dec_sel = 2'd0;
        casez (prefix)
            4'b000?: dec_sel = 2'd0;
            4'b0100: dec_sel = 2'd1;
            4'b0101: dec_sel = 2'd2;
            4'b011?: dec_sel = 2'd3;
            default: dec_hit = 1'b0;
        endcase
    end

    // Responses of the latched target only; other targets are never looked at.
    always_comb begin
        tgt_stall = wbt_stall_i[sel_q];
        tgt_ack   = wbt_ack_i[sel_q];
        tgt_rdata = wbt_data_i[DATA_WIDTH*int'(sel_q) +: DATA_WIDTH];
        cnt_inc   = cnt_q + 16'd1;
        timeout   = (cnt_inc == TO_LIMIT);
        take      = ~tgt_stall;
    end

    // Next-state logic: abort beats ack, ack beats timeout.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        cyc_d   = cyc_q;
        stb_d   = stb_q;

        case (state_q)
            S_IDLE: begin
                if (wbi_cyc_i && wbi_stb_i) begin
                    addr_d  = wbi_addr_i;
                    wdata_d = wbi_data_i;
                    we_d    = wbi_we_i;
                    sel_d   = dec_sel;
                    cnt_d   = 16'd0;
                    if (dec_hit) begin
                        state_d = S_REQ;
                        cyc_d   = 4'b0001 << dec_sel;
                        stb_d   = 4'b0001 << dec_sel;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end

            S_REQ: begin
                cnt_d = cnt_inc;
                if (!wbi_cyc_i) begin
                    state_d = S_IDLE;
                    cyc_d   = 4'b0000;
                    stb_d   = 4'b0000;
                end else if (take && tgt_ack) begin
                    // Target took the strobe and acked in the same cycle.
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                    cyc_d   = 4'b0000;
                    stb_d   = 4'b0000;
                    if (!we_q) begin
                        rdata_d = tgt_rdata;
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                    cyc_d   = 4'b0000;
                    stb_d   = 4'b0000;
                end else if (take) begin
                    state_d = S_WAIT;
                    stb_d   = 4'b0000;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_inc;
                if (!wbi_cyc_i) begin
                    state_d = S_IDLE;
                    cyc_d   = 4'b0000;
                    stb_d   = 4'b0000;
                end else if (tgt_ack) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                    cyc_d   = 4'b0000;
                    stb_d   = 4'b0000;
                    if (!we_q) begin
                        rdata_d = tgt_rdata;
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                    cyc_d   = 4'b0000;
                    stb_d   = 4'b0000;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= 2'd0;
            cnt_q   <= 16'd0;
            ack_q   <= 1'b0;
            cyc_q   <= 4'b0000;
            stb_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
        end
    end

    assign wbi_stall_o = (state_q != S_IDLE);
    assign wbi_err_o   = (state_q == S_ERR);
    assign wbi_ack_o   = ack_q;
    assign wbi_data_o  = rdata_q;

    assign wbt_addr_o  = addr_q;
    assign wbt_data_o  = wdata_q;
    assign wbt_we_o    = we_q;
    assign wbt_cyc_o   = cyc_q;
    assign wbt_stb_o   = stb_q;

endmodule

// File: tb/tb_wb_target_decode.sv
// Directed bench for wb_target_decode with a response scoreboard.
// Expected ack/err responses are queued at drive time and popped on output.
module tb_wb_target_decode;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] wbi_addr_i;
    logic [7:0]  wbi_data_i;
    logic [7:0]  wbi_data_o;
    logic        wbi_we_i;
    logic        wbi_cyc_i;
    logic        wbi_stb_i;
    logic        wbi_stall_o;
    logic        wbi_ack_o;
    logic        wbi_err_o;
    logic [19:0] wbt_addr_o;
    logic [7:0]  wbt_data_o;
    logic        wbt_we_o;
    logic [3:0]  wbt_cyc_o;
    logic [3:0]  wbt_stb_o;
    logic [3:0]  wbt_stall_i;
    logic [3:0]  wbt_ack_i;
    logic [31:0] wbt_data_i;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sbq[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] exp_rd  = 8'h00;

    always #5 clk = ~clk;

    wb_target_decode #(
        .TIMEOUT_CYCLES(TO),
        .WB_ADDR_WIDTH (20),
        .DATA_WIDTH    (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_reset_i  (rst),
        .wbi_addr_i  (wbi_addr_i),
        .wbi_data_i  (wbi_data_i),
        .wbi_data_o  (wbi_data_o),
        .wbi_we_i    (wbi_we_i),
        .wbi_cyc_i   (wbi_cyc_i),
        .wbi_stb_i   (wbi_stb_i),
        .wbi_stall_o (wbi_stall_o),
        .wbi_ack_o   (wbi_ack_o),
        .wbi_err_o   (wbi_err_o),
        .wbt_addr_o  (wbt_addr_o),
        .wbt_data_o  (wbt_data_o),
        .wbt_we_o    (wbt_we_o),
        .wbt_cyc_o   (wbt_cyc_o),
        .wbt_stb_o   (wbt_stb_o),
        .wbt_stall_i (wbt_stall_i),
        .wbt_ack_i   (wbt_ack_i),
        .wbt_data_i  (wbt_data_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the falling edge and settle any response against the queue.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (wbi_ack_o === 1'b1 || wbi_err_o === 1'b1) begin
            chk("ack_err_excl", 32'(wbi_ack_o & wbi_err_o), 32'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 32'({wbi_ack_o, wbi_err_o}), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_err", 32'(wbi_err_o), 32'(e.is_err));
                chk("resp_ack", 32'(wbi_ack_o), 32'(!e.is_err));
                if (!e.is_err) chk("resp_data", 32'(wbi_data_o), 32'(e.data));
            end
        end
    endtask

    task automatic drive_req(input logic [19:0] a, input logic we,
                             input logic [7:0] wd);
        wbi_addr_i = a;
        wbi_we_i   = we;
        wbi_data_i = wd;
        wbi_cyc_i  = 1'b1;
        wbi_stb_i  = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_stall"}, 32'(wbi_stall_o), 32'd0);
        chk({tag, "_ack"},   32'(wbi_ack_o),   32'd0);
        chk({tag, "_err"},   32'(wbi_err_o),   32'd0);
        chk({tag, "_cyc"},   32'(wbt_cyc_o),   32'd0);
        chk({tag, "_stb"},   32'(wbt_stb_o),   32'd0);
    endtask

    task automatic mapped(input logic [19:0] a, input logic we,
                          input logic [7:0] wd, input logic [7:0] rd,
                          input int tgt, input int stalls, input bit early);
        logic [3:0] oh;
        oh = 4'(1 << tgt);
        if (!we) exp_rd = rd;
        sbq.push_back('{is_err: 1'b0, data: exp_rd});
        wbt_data_i = {4{~rd}};
        wbt_data_i[8*tgt +: 8] = rd;
        wbt_stall_i = 4'h0;
        wbt_ack_i   = 4'h0;
        drive_req(a, we, wd);
        step();
        chk("stb_sel",    32'(wbt_stb_o),   32'(oh));
        chk("cyc_sel",    32'(wbt_cyc_o),   32'(oh));
        chk("t_addr",     32'(wbt_addr_o),  32'(a));
        chk("t_data",     32'(wbt_data_o),  32'(wd));
        chk("t_we",       32'(wbt_we_o),    32'(we));
        chk("stall_busy", 32'(wbi_stall_o), 32'd1);
        wbi_stb_i = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            wbt_stall_i = 4'hF;
            wbt_ack_i   = ~oh;
            step();
            chk("stb_held", 32'(wbt_stb_o), 32'(oh));
        end
        wbt_stall_i = 4'h0;
        wbt_ack_i   = 4'h0;
        if (early) begin
            wbt_ack_i = oh;
            step();
            chk("ack_early", 32'(wbi_ack_o), 32'd1);
            chk("cyc_drop",  32'(wbt_cyc_o), 32'd0);
        end else begin
            step();
            chk("stb_drop",   32'(wbt_stb_o), 32'd0);
            chk("cyc_keep",   32'(wbt_cyc_o), 32'(oh));
            chk("no_ack_yet", 32'(wbi_ack_o), 32'd0);
            wbt_ack_i = oh;
            step();
            chk("ack_pulse", 32'(wbi_ack_o), 32'd1);
            chk("cyc_drop",  32'(wbt_cyc_o), 32'd0);
        end
        wbt_ack_i = 4'h0;
        wbi_cyc_i = 1'b0;
        step();
        chk("ack_one_cycle", 32'(wbi_ack_o), 32'd0);
        chk("stall_free",    32'(wbi_stall_o), 32'd0);
    endtask

    task automatic unmapped(input logic [19:0] a);
        sbq.push_back('{is_err: 1'b1, data: 8'h00});
        drive_req(a, 1'b0, 8'h00);
        step();
        chk("err_pulse",    32'(wbi_err_o), 32'd1);
        chk("err_no_cyc",   32'(wbt_cyc_o), 32'd0);
        chk("err_no_stb",   32'(wbt_stb_o), 32'd0);
        chk("err_no_ack",   32'(wbi_ack_o), 32'd0);
        wbi_cyc_i = 1'b0;
        wbi_stb_i = 1'b0;
        step();
        chk("err_one_cycle", 32'(wbi_err_o), 32'd0);
        chk("err_idle_stall", 32'(wbi_stall_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        wbi_addr_i  = 20'h0;
        wbi_data_i  = 8'h0;
        wbi_we_i    = 1'b0;
        wbi_cyc_i   = 1'b0;
        wbi_stb_i   = 1'b0;
        wbt_stall_i = 4'h0;
        wbt_ack_i   = 4'h0;
        wbt_data_i  = 32'h0;
        step();
        step();
        chk_idle_outputs("rst");
        chk("rst_data",  32'(wbi_data_o), 32'd0);
        chk("rst_taddr", 32'(wbt_addr_o), 32'd0);
        chk("rst_tdata", 32'(wbt_data_o), 32'd0);
        chk("rst_twe",   32'(wbt_we_o),   32'd0);
        rst = 1'b0;
        step();

        mapped(20'h08000, 1'b0, 8'h00, 8'hA5, 0, 0, 1'b0);
        mapped(20'h5001F, 1'b1, 8'h3C, 8'h77, 2, 0, 1'b0);
        mapped(20'h60009, 1'b0, 8'h00, 8'h5E, 3, 1, 1'b0);
        mapped(20'h40001, 1'b0, 8'h00, 8'hC3, 1, 0, 1'b1);
        mapped(20'h1FFFF, 1'b1, 8'h99, 8'h11, 0, 2, 1'b0);
        mapped(20'h7FFFF, 0, 8'h00, 8'h6B, 3, 0, 1'b0);

        unmapped(20'h80000);
        unmapped(20'h20000);
        unmapped(20'hFFFFF);

        // RAM target that never acks.
        sbq.push_back('{is_err: 1'b1, data: 8'h00});
        wbt_stall_i = 4'h0;
        wbt_ack_i   = 4'h0;
        drive_req(20'h00010, 1'b0, 8'h00);
        step();
        wbi_stb_i = 1'b0;
        for (int k = 2; k <= TO + 1; k++) begin
            step();
            if (k <= TO) begin
                chk("to_no_err", 32'(wbi_err_o), 32'd0);
                chk("to_cyc",    32'(wbt_cyc_o), 32'd1);
            end else begin
                chk("to_err",      32'(wbi_err_o), 32'd1);
                chk("to_cyc_drop", 32'(wbt_cyc_o), 32'd0);
            end
        end
        wbi_cyc_i = 1'b0;
        step();
        chk("to_err_one", 32'(wbi_err_o), 32'd0);

        // REG stalls, then the initiator abandons the cycle.
        drive_req(20'h40001, 1'b0, 8'h00);
        step();
        chk("ab_stb", 32'(wbt_stb_o), 32'h2);
        wbi_stb_i   = 1'b0;
        wbt_stall_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ab_stb_held", 32'(wbt_stb_o), 32'h2);
        end
        wbi_cyc_i = 1'b0;
        step();
        chk_idle_outputs("abort");
        wbt_stall_i = 4'h0;
        wbt_ack_i   = 4'h2;
        step();
        chk("late_ack_ack", 32'(wbi_ack_o), 32'd0);
        chk("late_ack_err", 32'(wbi_err_o), 32'd0);
        wbt_ack_i = 4'h0;
        mapped(20'h00123, 1'b0, 8'h00, 8'h3E, 0, 0, 1'b0);

        // Reset in the middle of a request.
        drive_req(20'h00200, 1'b0, 8'h00);
        step();
        chk("mid_cyc", 32'(wbt_cyc_o), 32'h1);
        rst       = 1'b1;
        wbi_cyc_i = 1'b0;
        wbi_stb_i = 1'b0;
        step();
        chk_idle_outputs("midrst");
        chk("midrst_data", 32'(wbi_data_o), 32'd0);
        exp_rd = 8'h00;
        rst = 1'b0;
        step();
        mapped(20'h50002, 1'b1, 8'h44, 8'hEE, 2, 0, 1'b0);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
